esi_pipeline_fifo: RTL and testbench

ESI_PIPELINE_FIFO -- requirements
Module: esi_pipeline_fifo

---
 rtl/esi_prims_pkg.sv | 33 +++
 rtl/esi_fifo_ram.sv | 36 +++
 rtl/esi_pipeline_fifo.sv | 159 +++++++++++++++
 tb/tb_esi_pipeline_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/esi_prims_pkg.sv
// ---------------------------------------------------------------------------
// esi_prims_pkg
// Shared width helpers for the ESI primitive blocks.
//   ptr_w(depth)   : read/write pointer width for a circular buffer of depth
//   cnt_w(depth)   : width of a storage count that can hold 0..depth
//   level_w(depth) : width of an occupancy level that can hold 0..depth+1
//                    (storage entries plus one output register)
//   level_t        : level type for the default depth
// ---------------------------------------------------------------------------
package esi_prims_pkg;

  localparam int DEFAULT_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    // A depth-1 buffer would need a 0-bit pointer; clamp to 1.
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth + 2);
  endfunction

  localparam int DEFAULT_PTR_W   = ptr_w(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W   = cnt_w(DEFAULT_DEPTH);
  localparam int DEFAULT_LEVEL_W = level_w(DEFAULT_DEPTH);

  typedef logic [DEFAULT_LEVEL_W-1:0] level_t;

endpackage : esi_prims_pkg

// File: rtl/esi_fifo_ram.sv
// ---------------------------------------------------------------------------
// esi_fifo_ram
// WIDTH x DEPTH storage array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk    : write clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// ---------------------------------------------------------------------------
module esi_fifo_ram
  import esi_prims_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : esi_fifo_ram

// File: rtl/esi_pipeline_fifo.sv
// ---------------------------------------------------------------------------
// esi_pipeline_fifo
// Latency-insensitive pipeline FIFO: a DEPTH-entry circular buffer followed
// by one output register. Sustains one token per cycle.
//
// Handshake: a token moves on a channel in any cycle where valid && ready are
// both high at the rising edge of clk. Once x_valid is high it stays high and
// x stays constant until x_ready is seen. a_ready and x_valid come straight
// from flops, so there is no combinational path between the two channels.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous, active-low reset
//   a_valid/a     : input channel valid / payload
//   a_ready       : input channel ready (storage count < DEPTH, registered)
//   x_valid/x     : output channel valid / payload
//   x_ready       : output channel ready
//   level         : tokens held, storage plus output register (0..DEPTH+1)
//   a_almost_full : level >= AFULL_THRESH
//
// Configuration
//   ESI_FIFO_BYPASS_EN : when defined, a token accepted while storage is
//                        empty and the output register is free (or leaving
//                        this cycle) is loaded straight into the output
//                        register: x_valid one cycle after accept. When not
//                        defined, every token goes through storage: x_valid
//                        two cycles after accept into an empty FIFO.
// ---------------------------------------------------------------------------
module esi_pipeline_fifo
  import esi_prims_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [WIDTH-1:0]           a,
  output logic                       a_ready,
  output logic                       x_valid,
  output logic [WIDTH-1:0]           x,
  input  logic                       x_ready,
  output logic [$clog2(DEPTH+2)-1:0] level,
  output logic                       a_almost_full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  // Registered state
  logic [PTR_W-1:0] wptr_q,    wptr_d;
  logic [PTR_W-1:0] rptr_q,    rptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [LVL_W-1:0] level_q,   level_d;
  logic             a_ready_q, a_ready_d;
  logic             x_valid_q, x_valid_d;
  logic [WIDTH-1:0] x_q,       x_d;

  // Per-cycle events
  logic             accept;
  logic             xfer;
  logic             out_free;
  logic             stor_empty;
  logic             pop;
  logic             push;
  logic             bypass;
  logic [WIDTH-1:0] rd_data;

  esi_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (a),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    accept     = a_valid && a_ready_q;
    xfer       = x_valid_q && x_ready;
    // The output register can take a new token if it is empty or its current
    // token leaves this cycle; refilling on transfer gives full throughput.
    out_free   = xfer || !x_valid_q;
    stor_empty = (count_q == '0);
    pop        = out_free && !stor_empty;
`ifdef ESI_FIFO_BYPASS_EN
    bypass     = out_free && stor_empty && accept;
`else
    bypass     = 1'b0;
`endif
    push       = accept && !bypass;

    x_d       = x_q;
    x_valid_d = x_valid_q;
    if (pop) begin
      x_d       = rd_data;
      x_valid_d = 1'b1;
    end else if (bypass) begin
      x_d       = a;
      x_valid_d = 1'b1;
    end else if (xfer) begin
      x_valid_d = 1'b0;
    end

    // DEPTH is a power of two, so pointers wrap modulo DEPTH on overflow.
    wptr_d  = wptr_q + PTR_W'(push);
    rptr_d  = rptr_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    level_d = level_q + LVL_W'(accept) - LVL_W'(xfer);

    // Ready for next cycle is decided from next cycle's storage count, so a
    // pop this cycle re-opens the input one cycle later.
    a_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      level_q   <= '0;
      a_ready_q <= 1'b0;
      x_valid_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      level_q   <= level_d;
      a_ready_q <= a_ready_d;
      x_valid_q <= x_valid_d;
    end
  end

  // Payload register needs no reset: it is only observed while x_valid is set.
  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

  assign a_ready       = a_ready_q;
  assign x_valid       = x_valid_q;
  assign x             = x_q;
  assign level         = level_q;
  assign a_almost_full = (level_q >= LVL_W'(AFULL_THRESH));

`ifndef SYNTHESIS
  // Writing into full storage would overwrite the oldest unread token.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(accept && (count_q == CNT_W'(DEPTH))));
    end
  end
`endif

endmodule : esi_pipeline_fifo

// File: tb/tb_esi_pipeline_fifo.sv
// ---------------------------------------------------------------------------
// tb_esi_pipeline_fifo
// Bench for esi_pipeline_fifo (WIDTH=8, DEPTH=4). Honours ESI_FIFO_BYPASS_EN
// the same way the design does.
// ---------------------------------------------------------------------------
module tb_esi_pipeline_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;
`ifdef ESI_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk     = 1'b0;
  logic             rst     = 1'b0;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a       = '0;
  logic             x_ready = 1'b0;
  logic             a_ready;
  logic             x_valid;
  logic [WIDTH-1:0] x;
  logic [2:0]       level;
  logic             a_almost_full;

  always #5 clk = ~clk;

  esi_pipeline_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a_valid       (a_valid),
    .a             (a),
    .a_ready       (a_ready),
    .x_valid       (x_valid),
    .x             (x),
    .x_ready       (x_ready),
    .level         (level),
    .a_almost_full (a_almost_full)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // exp_q holds every accepted, not yet transferred token in order; its head
  // must be what x shows whenever x_valid is expected. m_sc is how many of
  // those tokens sit in storage rather than in the output slot.
  logic [WIDTH-1:0] exp_q[$];
  int m_sc      = 0;
  bit m_out_v   = 1'b0;
  bit m_ready   = 1'b0;
  bit started   = 1'b0;

  always @(posedge clk) begin : model
    bit acc;
    bit xf;
    bit byp;
    if (!rst) begin
      exp_q.delete();
      m_sc    = 0;
      m_out_v = 1'b0;
      m_ready = 1'b0;
      started = 1'b1;
    end else begin
      acc = a_valid && m_ready;
      xf  = m_out_v && x_ready;
      byp = 1'b0;
      if (acc) exp_q.push_back(a);
      if (xf) void'(exp_q.pop_front());
      if (xf || !m_out_v) begin
        if (m_sc > 0) begin
          m_sc--;
          m_out_v = 1'b1;
        end else if (BYP && acc) begin
          m_out_v = 1'b1;
          byp     = 1'b1;
        end else begin
          m_out_v = 1'b0;
        end
      end
      if (acc && !byp) m_sc++;
      m_ready = (m_sc < DEPTH);
    end
  end

  // Compare on the falling edge, halfway between input changes and clk rise.
  always @(negedge clk) begin : compare
    int lvl;
    if (started) begin
      lvl = m_sc + int'(m_out_v);
      chk("a_ready", int'(a_ready), int'(m_ready));
      chk("x_valid", int'(x_valid), int'(m_out_v));
      chk("level", int'(level), lvl);
      chk("a_almost_full", int'(a_almost_full), int'(lvl >= AFULL));
      if (m_out_v) chk("x_data", int'(x), int'(exp_q[0]));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] nxt;
    int first_c, last_c, acc_n, ins, outs, rdy_low, seen, acc_total;

    // Reset
    rst = 1'b0;
    repeat (2) step();
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_level", int'(level), 0);
    rst = 1'b1;
    step();
    chk("ready_after_rst", int'(a_ready), 1);

    // Single push into an empty FIFO: latency 1 with bypass, 2 without.
    a_valid = 1'b1;
    a       = 8'hA5;
    step();
    a_valid = 1'b0;
    chk("a5_valid_n1", int'(x_valid), int'(BYP));
    step();
    chk("a5_valid_n2", int'(x_valid), 1);
    chk("a5_data", int'(x), 'hA5);
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;
    chk("a5_drained", int'(level), 0);

    // 0x01..0x10 back-to-back with x_ready held high.
    x_ready = 1'b1;
    nxt     = 8'h01;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 40; c++) begin
      a_valid = (nxt <= 8'h10);
      a       = nxt;
      if (x_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got.push_back(x);
      end
      if (a_valid && a_ready) nxt++;
      step();
    end
    a_valid = 1'b0;
    chk("stream_count", got.size(), 16);
    chk("stream_first_cycle", first_c, BYP ? 1 : 2);
    chk("stream_no_gaps", last_c - first_c, 15);
    for (int i = 0; i < got.size(); i++) chk("stream_order", int'(got[i]), i + 1);

    // Fill with x_ready low: DEPTH+1 tokens accepted, then stall.
    x_ready = 1'b0;
    nxt     = 8'h20;
    acc_n   = 0;
    for (int c = 0; c < 12; c++) begin
      a_valid = 1'b1;
      a       = nxt;
      if (a_ready) begin
        acc_n++;
        nxt++;
      end
      step();
    end
    a_valid = 1'b0;
    chk("fill_accepted", acc_n, DEPTH + 1);
    chk("fill_a_ready", int'(a_ready), 0);
    chk("fill_level", int'(level), DEPTH + 1);
    chk("fill_afull", int'(a_almost_full), 1);
    chk("fill_x_valid", int'(x_valid), 1);
    chk("fill_x_head", int'(x), 'h20);

    // Streaming from full. a_ready is registered from the storage count, so
    // the first cycle is transfer-only; after that one in and one out per
    // cycle with level holding at DEPTH.
    x_ready = 1'b1;
    ins     = 0;
    outs    = 0;
    rdy_low = 0;
    for (int c = 0; c < 11; c++) begin
      a_valid = 1'b1;
      a       = nxt;
      if (a_ready) begin
        ins++;
        nxt++;
      end else if (c > 0) begin
        rdy_low++;
      end
      if (x_valid) outs++;
      step();
    end
    a_valid = 1'b0;
    x_ready = 1'b0;
    chk("stream_full_ins", ins, 10);
    chk("stream_full_outs", outs, 11);
    chk("stream_full_ready_drop", rdy_low, 0);
    chk("stream_full_level", int'(level), DEPTH);

    // Mid-operation reset with three tokens held.
    x_ready = 1'b1;
    repeat (8) step();
    x_ready = 1'b0;
    chk("drain_level", int'(level), 0);
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1;
      a       = 8'h40 + 8'(k);
      step();
    end
    a_valid = 1'b0;
    chk("pre_rst_level", int'(level), 3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_x_valid", int'(x_valid), 0);
    chk("mid_rst_level", int'(level), 0);
    step();
    chk("mid_rst_a_ready", int'(a_ready), 1);
    x_ready = 1'b1;
    seen    = 0;
    repeat (6) begin
      if (x_valid) seen++;
      step();
    end
    x_ready = 1'b0;
    chk("no_stale_tokens", seen, 0);

    // Random traffic, 50% on each side.
    acc_total = 0;
    for (int c = 0; c < 10000; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      a       = 8'($urandom_range(0, 255));
      x_ready = 1'($urandom_range(0, 1));
      if (a_valid && a_ready) acc_total++;
      step();
    end
    a_valid = 1'b0;
    x_ready = 1'b1;
    repeat (12) step();
    chk("random_drained", int'(level), 0);
    chk("random_many_wraps", int'(acc_total >= 100 * DEPTH), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_esi_pipeline_fifo
